// File: rtl/sudoku_pkg.sv
// Shared constants, state encoding and requester IDs for the puzzle RAM arbiter.
package sudoku_pkg;

    localparam int ROWS   = 4;
    localparam int CELL_W = 5;
    localparam int ROW_W  = 4 * CELL_W;
    localparam int ADDR_W = 2;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RDATA  = 2'd3
    } state_t;

    localparam logic REQ_CTRL = 1'b0;
    localparam logic REQ_CHK  = 1'b1;

endpackage

// File: rtl/sudoku_ram_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to whoever did not win last.
module rr_pick2
    import sudoku_pkg::*;
(
    input  logic [1:0] req_i,     // bit 0 = controller, bit 1 = checker
    input  logic       last_i,    // previous winner id
    output logic [1:0] grant_o,   // one-hot grant
    output logic       winner_o   // winner id, meaningful when grant_o != 0
);

    // Combinational winner selection
    always_comb begin
        grant_o  = 2'b00;
        winner_o = REQ_CTRL;
        case (req_i)
            2'b01: begin
                grant_o  = 2'b01;
                winner_o = REQ_CTRL;
            end
            2'b10: begin
                grant_o  = 2'b10;
                winner_o = REQ_CHK;
            end
            2'b11: begin
                if (last_i == REQ_CHK) begin
                    grant_o  = 2'b01;
                    winner_o = REQ_CTRL;
                end else begin
                    grant_o  = 2'b10;
                    winner_o = REQ_CHK;
                end
            end
            default: begin
                grant_o  = 2'b00;
                winner_o = REQ_CTRL;
            end
        endcase
    end

endmodule

// File: rtl/sudoku_ram_arbiter.sv
// Puzzle RAM port arbiter: loads the start image after reset, then serves controller
// and checker accesses one at a time with round-robin priority.
module sudoku_ram_arbiter #(
    parameter int ROWS   = sudoku_pkg::ROWS,
    parameter int ROW_W  = sudoku_pkg::ROW_W,
    parameter int ADDR_W = sudoku_pkg::ADDR_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ROWS*ROW_W-1:0] init_rows,
    output logic                  init_done,
    input  logic                  ctrl_req,
    input  logic                  ctrl_we,
    input  logic [ADDR_W-1:0]     ctrl_addr,
    input  logic [ROW_W-1:0]      ctrl_wdata,
    output logic                  ctrl_gnt,
    output logic                  ctrl_rvalid,
    output logic [ROW_W-1:0]      ctrl_rdata,
    input  logic                  chk_req,
    input  logic [ADDR_W-1:0]     chk_addr,
    output logic                  chk_gnt,
    output logic                  chk_rvalid,
    output logic [ROW_W-1:0]      chk_rdata,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [ROW_W-1:0]      ram_wdata,
    output logic                  ram_wren,
    input  logic [ROW_W-1:0]      ram_q
);
    import sudoku_pkg::*;

    // The state register names the phase whose outputs are currently on the pins;
    // all RAM-side and handshake outputs are registered alongside it.
    state_t              state_q, state_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic                init_done_q, init_done_d;
    logic                last_q, last_d;
    logic                cap_id_q, cap_id_d;
    logic                cap_we_q, cap_we_d;
    logic                cap_oob_q, cap_oob_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [ROW_W-1:0]    ram_wdata_q, ram_wdata_d;
    logic                ram_wren_q, ram_wren_d;
    logic                ctrl_gnt_q, ctrl_gnt_d, chk_gnt_q, chk_gnt_d;
    logic                ctrl_rvalid_q, ctrl_rvalid_d, chk_rvalid_q, chk_rvalid_d;
    logic [ROW_W-1:0]    ctrl_rdata_q, ctrl_rdata_d, chk_rdata_q, chk_rdata_d;

    logic [1:0]          pick_grant_s;
    logic                pick_id_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic                sel_we_s;
    logic [ROW_W-1:0]    sel_wdata_s;
    logic                sel_oob_s;
    logic [ROW_W-1:0]    rd_data_s;

    rr_pick2 u_pick (
        .req_i    ({chk_req, ctrl_req}),
        .last_i   (last_q),
        .grant_o  (pick_grant_s),
        .winner_o (pick_id_s)
    );

    // The checker is read-only, so its write enable and write data are tied off here
    assign sel_addr_s  = (pick_id_s == REQ_CHK) ? chk_addr : ctrl_addr;
    assign sel_we_s    = (pick_id_s == REQ_CTRL) ? ctrl_we : 1'b0;
    assign sel_wdata_s = (pick_id_s == REQ_CTRL) ? ctrl_wdata : {ROW_W{1'b0}};
    assign sel_oob_s   = (int'(sel_addr_s) >= ROWS);

    // RAM data arrives one cycle after the address, i.e. during RDATA, so the
    // winner's rdata is passed straight through then and held afterwards
    assign rd_data_s  = cap_oob_q ? {ROW_W{1'b0}} : ram_q;
    assign ctrl_rdata = ctrl_rvalid_q ? rd_data_s : ctrl_rdata_q;
    assign chk_rdata  = chk_rvalid_q ? rd_data_s : chk_rdata_q;

    assign init_done   = init_done_q;
    assign ctrl_gnt    = ctrl_gnt_q;
    assign chk_gnt     = chk_gnt_q;
    assign ctrl_rvalid = ctrl_rvalid_q;
    assign chk_rvalid  = chk_rvalid_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_wren    = ram_wren_q;

    // Next-state and next-output logic for the load / arbitrate / access sequence
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        init_done_d   = init_done_q;
        last_d        = last_q;
        cap_id_d      = cap_id_q;
        cap_we_d      = cap_we_q;
        cap_oob_d     = cap_oob_q;
        ram_addr_d    = {ADDR_W{1'b0}};
        ram_wdata_d   = {ROW_W{1'b0}};
        ram_wren_d    = 1'b0;
        ctrl_gnt_d    = 1'b0;
        chk_gnt_d     = 1'b0;
        ctrl_rvalid_d = 1'b0;
        chk_rvalid_d  = 1'b0;
        ctrl_rdata_d  = ctrl_rdata_q;
        chk_rdata_d   = chk_rdata_q;
        case (state_q)
            ST_INIT: begin
                if (int'(idx_q) < ROWS) begin
                    ram_addr_d  = idx_q[ADDR_W-1:0];
                    ram_wdata_d = init_rows[int'(idx_q)*ROW_W +: ROW_W];
                    ram_wren_d  = 1'b1;
                    idx_d       = idx_q + {{ADDR_W{1'b0}}, 1'b1};
                end else begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (|pick_grant_s) begin
                    cap_id_d    = pick_id_s;
                    cap_we_d    = sel_we_s;
                    cap_oob_d   = sel_oob_s;
                    ram_addr_d  = sel_addr_s;
                    ram_wdata_d = sel_wdata_s;
                    ram_wren_d  = sel_we_s & ~sel_oob_s;
                    ctrl_gnt_d  = pick_grant_s[0];
                    chk_gnt_d   = pick_grant_s[1];
                    last_d      = pick_id_s;
                    state_d     = ST_ACCESS;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!cap_we_q) begin
                    ctrl_rvalid_d = (cap_id_q == REQ_CTRL);
                    chk_rvalid_d  = (cap_id_q == REQ_CHK);
                    state_d       = ST_RDATA;
                end else begin
                    state_d       = ST_IDLE;
                end
            end
            ST_RDATA: begin
                if (ctrl_rvalid_q) begin
                    ctrl_rdata_d = rd_data_s;
                end else begin
                    chk_rdata_d  = rd_data_s;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = {(ADDR_W+1){1'b0}};
            end
        endcase
    end

    // State and registered-output update; reset abandons any access and restarts the load
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_INIT;
            idx_q         <= {(ADDR_W+1){1'b0}};
            init_done_q   <= 1'b0;
            last_q        <= REQ_CHK;
            cap_id_q      <= REQ_CTRL;
            cap_we_q      <= 1'b0;
            cap_oob_q     <= 1'b0;
            ram_addr_q    <= {ADDR_W{1'b0}};
            ram_wdata_q   <= {ROW_W{1'b0}};
            ram_wren_q    <= 1'b0;
            ctrl_gnt_q    <= 1'b0;
            chk_gnt_q     <= 1'b0;
            ctrl_rvalid_q <= 1'b0;
            chk_rvalid_q  <= 1'b0;
            ctrl_rdata_q  <= {ROW_W{1'b0}};
            chk_rdata_q   <= {ROW_W{1'b0}};
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            init_done_q   <= init_done_d;
            last_q        <= last_d;
            cap_id_q      <= cap_id_d;
            cap_we_q      <= cap_we_d;
            cap_oob_q     <= cap_oob_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            ram_wren_q    <= ram_wren_d;
            ctrl_gnt_q    <= ctrl_gnt_d;
            chk_gnt_q     <= chk_gnt_d;
            ctrl_rvalid_q <= ctrl_rvalid_d;
            chk_rvalid_q  <= chk_rvalid_d;
            ctrl_rdata_q  <= ctrl_rdata_d;
            chk_rdata_q   <= chk_rdata_d;
        end
    end

endmodule

// File: tb/tb_sudoku_ram_arbiter.sv
// Directed + randomized bench for sudoku_ram_arbiter with a behavioural RAM and
// a reference model of memory contents and round-robin winner history.
module tb_sudoku_ram_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [79:0] init_rows = 80'd0;
    logic        init_done;
    logic        ctrl_req = 1'b0, ctrl_we = 1'b0;
    logic [1:0]  ctrl_addr = 2'd0;
    logic [19:0] ctrl_wdata = 20'd0;
    logic        ctrl_gnt, ctrl_rvalid;
    logic [19:0] ctrl_rdata;
    logic        chk_req = 1'b0;
    logic [1:0]  chk_addr = 2'd0;
    logic        chk_gnt, chk_rvalid;
    logic [19:0] chk_rdata;
    logic [1:0]  ram_addr;
    logic [19:0] ram_wdata;
    logic        ram_wren;
    logic [19:0] ram_q = 20'd0;

    logic [19:0] ram_mem [4];

    // reference model state
    logic [19:0] exp_mem [4];
    logic        last_chk;
    logic [19:0] exp_ctrl_rd, exp_chk_rd;
    int          tests = 0, fails = 0, cyc = 0, rv_cyc = 0, prev_rv = 0;

    sudoku_ram_arbiter dut (
        .CLK(CLK), .RST(RST), .init_rows(init_rows), .init_done(init_done),
        .ctrl_req(ctrl_req), .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr),
        .ctrl_wdata(ctrl_wdata), .ctrl_gnt(ctrl_gnt), .ctrl_rvalid(ctrl_rvalid),
        .ctrl_rdata(ctrl_rdata), .chk_req(chk_req), .chk_addr(chk_addr),
        .chk_gnt(chk_gnt), .chk_rvalid(chk_rvalid), .chk_rdata(chk_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 CLK = ~CLK;

    // synchronous single-port RAM: registered read, one cycle latency
    always @(posedge CLK) begin
        if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
        ram_q <= ram_mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Load a fresh image into the model and the DUT input
    task automatic set_image(input bit rnd);
        for (int i = 0; i < 4; i++) begin
            exp_mem[i] = rnd ? 20'($urandom) : (20'h10000 + 20'(i));
            init_rows[i*20 +: 20] = exp_mem[i];
        end
    endtask

    // Follow the load sweep that starts on the first edge after reset release
    task automatic check_sweep();
        for (int k = 0; k < 4; k++) begin
            step();
            check("init_wren", 32'(ram_wren), 32'd1);
            check("init_addr", 32'(ram_addr), 32'(k));
            check("init_wdata", 32'(ram_wdata), 32'(exp_mem[k]));
            check("init_nognt", {30'd0, ctrl_gnt, chk_gnt}, 32'd0);
            check("init_notdone", 32'(init_done), 32'd0);
        end
        step();
        check("init_done", 32'(init_done), 32'd1);
        check("idle_wren", 32'(ram_wren), 32'd0);
        check("idle_nognt", {30'd0, ctrl_gnt, chk_gnt}, 32'd0);
    endtask

    // Serve one access starting in an IDLE cycle with at least one request pending
    task automatic serve(input bit hold);
        bit          win_chk;
        logic        we;
        logic [1:0]  a;
        logic [19:0] wd;
        if (ctrl_req && chk_req) win_chk = !last_chk;
        else                     win_chk = chk_req;
        we = win_chk ? 1'b0 : ctrl_we;
        a  = win_chk ? chk_addr : ctrl_addr;
        wd = ctrl_wdata;
        step();
        check("gnt_ctrl", 32'(ctrl_gnt), 32'(!win_chk));
        check("gnt_chk", 32'(chk_gnt), 32'(win_chk));
        check("acc_addr", 32'(ram_addr), 32'(a));
        check("acc_wren", 32'(ram_wren), 32'(we));
        last_chk = win_chk;
        if (!hold) begin
            if (win_chk) chk_req = 1'b0;
            else         ctrl_req = 1'b0;
        end
        if (we) begin
            check("acc_wdata", 32'(ram_wdata), 32'(wd));
            exp_mem[a] = wd;
            step();
            check("wr_idle", {29'd0, ctrl_gnt, chk_gnt, ram_wren}, 32'd0);
        end else begin
            if (win_chk) exp_chk_rd = exp_mem[a];
            else         exp_ctrl_rd = exp_mem[a];
            step();
            check("rv_ctrl", 32'(ctrl_rvalid), 32'(!win_chk));
            check("rv_chk", 32'(chk_rvalid), 32'(win_chk));
            check("rdata_ctrl", 32'(ctrl_rdata), 32'(exp_ctrl_rd));
            check("rdata_chk", 32'(chk_rdata), 32'(exp_chk_rd));
            rv_cyc = cyc;
            step();
            check("rd_idle", {28'd0, ctrl_rvalid, chk_rvalid, ctrl_gnt, chk_gnt}, 32'd0);
            check("rd_hold_ctrl", 32'(ctrl_rdata), 32'(exp_ctrl_rd));
        end
    endtask

    initial begin
        last_chk = 1'b1;
        exp_ctrl_rd = 20'd0;
        exp_chk_rd = 20'd0;
        set_image(1'b0);

        // reset state
        step();
        step();
        check("rst_outs", {26'd0, ram_wren, init_done, ctrl_gnt, chk_gnt, ctrl_rvalid, chk_rvalid}, 32'd0);
        check("rst_rdata", {12'd0, ctrl_rdata ^ chk_rdata}, 32'd0);
        check("rst_rdata_ctrl", 32'(ctrl_rdata), 32'd0);
        RST = 1'b0;

        // request during INIT: must wait for init_done
        ctrl_req = 1'b1; ctrl_we = 1'b0; ctrl_addr = 2'd1;
        check_sweep();
        serve(1'b0);

        // controller write then read-back of row 2
        ctrl_req = 1'b1; ctrl_we = 1'b1; ctrl_addr = 2'd2; ctrl_wdata = 20'hABCDE;
        serve(1'b0);
        ctrl_req = 1'b1; ctrl_we = 1'b0; ctrl_addr = 2'd2;
        serve(1'b0);
        check("wr_rd_back", 32'(ctrl_rdata), 32'h000ABCDE);

        // checker-only back-to-back reads: one rvalid every 3 cycles
        for (int i = 0; i < 4; i++) begin
            chk_req = 1'b1; chk_addr = 2'(i);
            serve(1'b0);
            if (i > 0) check("rd_rate", 32'(rv_cyc - prev_rv), 32'd3);
            prev_rv = rv_cyc;
        end

        // both requesters held high for 4 accesses: alternation
        ctrl_req = 1'b1; ctrl_we = 1'b0; ctrl_addr = 2'd2;
        chk_req = 1'b1; chk_addr = 2'd3;
        for (int i = 0; i < 4; i++) begin
            serve(1'b1);
            check("rr_order", 32'(last_chk), 32'(i % 2));
        end
        ctrl_req = 1'b0; chk_req = 1'b0;
        step();

        // randomized mix; requests stay stable until granted
        for (int i = 0; i < 24; i++) begin
            if (!ctrl_req) begin
                ctrl_req   = 1'($urandom_range(0, 1));
                ctrl_we    = 1'($urandom_range(0, 1));
                ctrl_addr  = 2'($urandom_range(0, 3));
                ctrl_wdata = 20'($urandom);
            end
            if (!chk_req) begin
                chk_req  = 1'($urandom_range(0, 1));
                chk_addr = 2'($urandom_range(0, 3));
            end
            if (!ctrl_req && !chk_req) chk_req = 1'b1;
            serve(1'b0);
        end
        ctrl_req = 1'b0; chk_req = 1'b0;
        step();

        // reset in the middle of a controller read
        ctrl_req = 1'b1; ctrl_we = 1'b0; ctrl_addr = 2'd3;
        step();
        check("mid_gnt", 32'(ctrl_gnt), 32'd1);
        #3;
        RST = 1'b1;
        #1;
        check("mid_rst_outs", {26'd0, ram_wren, init_done, ctrl_gnt, chk_gnt, ctrl_rvalid, chk_rvalid}, 32'd0);
        check("mid_rst_addr", 32'(ram_addr), 32'd0);
        check("mid_rst_rdata", 32'(ctrl_rdata | chk_rdata), 32'd0);
        step();
        check("mid_rst_norv", {30'd0, ctrl_rvalid, ram_wren}, 32'd0);
        ctrl_req = 1'b0;
        exp_ctrl_rd = 20'd0;
        exp_chk_rd = 20'd0;
        last_chk = 1'b1;
        set_image(1'b1);
        RST = 1'b0;
        check_sweep();

        // reload visible through both ports
        ctrl_req = 1'b1; ctrl_we = 1'b0; ctrl_addr = 2'd0;
        chk_req = 1'b1; chk_addr = 2'd3;
        serve(1'b0);
        serve(1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
